// File: rtl/reg_40xx_scan_reader.sv
// Streams a run of entries from a 40-deep register file over valid/ready.
// Optional REG40_SCAN_FWD_EN adds a write-snoop port that forwards same-cycle writes.
module reg_40xx_scan_reader #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [5:0]       start_addr,
    input  logic [5:0]       start_count,
    input  logic             abort,
    output logic [5:0]       rf_rd_addr,
    input  logic [WIDTH-1:0] rf_rd_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [5:0]       out_addr,
    output logic             busy,
    output logic             done,
    output logic             err
`ifdef REG40_SCAN_FWD_EN
    ,
    input  logic             snoop_wr_en,
    input  logic [5:0]       snoop_wr_addr,
    input  logic [WIDTH-1:0] snoop_wr_data
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [5:0]       ptr;
    logic [5:0]       remain;
    logic [5:0]       addr_hold;
    logic             start_ok;
    logic             cap;
    logic             hs;
    logic [WIDTH-1:0] cap_data;
    logic [5:0]       ptr_inc;

    assign start_ok = (start_addr <= 6'd39)
                   && (start_count != 6'd0)
                   && (start_count <= 6'd40);
    assign hs       = out_valid && out_ready;
    assign ptr_inc  = (ptr == 6'd39) ? 6'd0 : ptr + 6'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start && start_ok) begin
                        state_nxt = READ;
                    end
                end
                READ: begin
                    if (cap && remain == 6'd1) begin
                        state_nxt = DRAIN;
                    end
                end
                DRAIN: begin
                    if (hs) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        busy       = (state != IDLE);
        rf_rd_addr = (state == READ) ? ptr : addr_hold;
        cap        = (state == READ) && (!out_valid || out_ready) && !abort;
`ifdef REG40_SCAN_FWD_EN
        cap_data   = (snoop_wr_en && snoop_wr_addr == ptr) ? snoop_wr_data
                                                           : rf_rd_data;
`else
        cap_data   = rf_rd_data;
`endif
    end

    // addr_hold keeps the last presented address once READ is left
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= 6'd0;
            remain    <= 6'd0;
            addr_hold <= 6'd0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_addr  <= 6'd0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (state == READ) begin
                addr_hold <= ptr;
            end
            if (abort) begin
                out_valid <= 1'b0;
            end else begin
                if (state == IDLE && start) begin
                    if (start_ok) begin
                        ptr    <= start_addr;
                        remain <= start_count;
                    end else begin
                        err <= 1'b1;
                    end
                end
                if (cap) begin
                    out_data  <= cap_data;
                    out_addr  <= ptr;
                    out_valid <= 1'b1;
                    ptr       <= ptr_inc;
                    remain    <= remain - 6'd1;
                end else if (hs) begin
                    out_valid <= 1'b0;
                end
                if (state == DRAIN && hs) begin
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_reg_40xx_scan_reader.sv
// Scoreboard bench for reg_40xx_scan_reader with an 8-bit modelled register file.
// Expected entries are queued by stimulus and checked by a negedge monitor.
module tb_reg_40xx_scan_reader;

    localparam int W = 8;

    typedef struct packed {
        logic [5:0]   addr;
        logic [W-1:0] data;
    } ent_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [5:0]   start_addr;
    logic [5:0]   start_count;
    logic         abort;
    logic [5:0]   rf_rd_addr;
    logic [W-1:0] rf_rd_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [5:0]   out_addr;
    logic         busy;
    logic         done;
    logic         err;
    logic         wr_en;
    logic [5:0]   wr_addr;
    logic [W-1:0] wr_data;

    logic [W-1:0] file [40];
    ent_t         expq [$];
    int           total = 0;
    int           passed = 0;
    int           done_cnt = 0;
    logic         stall_prev = 1'b0;
    ent_t         prev_ent;

    always #5 clk = ~clk;

    assign rf_rd_data = (rf_rd_addr < 6'd40) ? file[rf_rd_addr] : '0;

    reg_40xx_scan_reader #(.WIDTH(W)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .start_addr(start_addr),
        .start_count(start_count),
        .abort(abort),
        .rf_rd_addr(rf_rd_addr),
        .rf_rd_data(rf_rd_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_addr(out_addr),
        .busy(busy),
        .done(done),
        .err(err)
`ifdef REG40_SCAN_FWD_EN
        ,
        .snoop_wr_en(wr_en),
        .snoop_wr_addr(wr_addr),
        .snoop_wr_data(wr_data)
`endif
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic push(input int a, input int n);
        int p;
        p = a;
        for (int i = 0; i < n; i++) begin
            expq.push_back({p[5:0], file[p]});
            p = (p == 39) ? 0 : p + 1;
        end
    endtask

    task automatic start_scan(input int a, input int n);
        start_addr  = a[5:0];
        start_count = n[5:0];
        start       = 1'b1;
        @(posedge clk); #1;
        start       = 1'b0;
    endtask

    task automatic wait_done(input int bound, input bit toggle,
                             output int cycles);
        bit seen;
        seen   = 1'b0;
        cycles = 0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(posedge clk); #1;
            cycles++;
            if (done) seen = 1'b1;
            else if (toggle) out_ready = ~out_ready;
        end
        check("done_seen", {31'd0, seen}, 32'd1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (stall_prev)
                check("stall_stable", {17'd0, out_valid, out_addr, out_data},
                      {17'd0, 1'b1, prev_ent.addr, prev_ent.data});
            if (out_valid)
                check("addr_range", {31'd0, out_addr < 6'd40}, 32'd1);
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    check("unexpected_out", {26'd0, out_addr}, 32'h3f);
                end else begin
                    ent_t e;
                    e = expq.pop_front();
                    check("out_entry", {18'd0, out_addr, out_data},
                          {18'd0, e.addr, e.data});
                end
            end
            stall_prev = out_valid && !out_ready;
            prev_ent   = {out_addr, out_data};
            if (done) done_cnt++;
        end else begin
            stall_prev = 1'b0;
        end
    end

    initial begin
        #300000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc;
        int d0;
        int bad_a [3];
        int bad_n [3];
        bad_a = '{0, 45, 10};
        bad_n = '{0, 3, 41};
        for (int i = 0; i < 40; i++) file[i] = W'(i + 100);
        rst = 1'b1; start = 1'b0; start_addr = 6'd0; start_count = 6'd0;
        abort = 1'b0; out_ready = 1'b1;
        wr_en = 1'b0; wr_addr = 6'd0; wr_data = '0;
        idle(3);
        rst = 1'b0;
        #1;
        check("rst_state",
              {16'd0, rf_rd_addr, out_valid, out_data, busy, done, err},
              32'd0);
        check("rst_out_addr", {26'd0, out_addr}, 32'd0);

        push(5, 3);
        d0 = done_cnt;
        start_scan(5, 3);
        wait_done(20, 1'b0, cyc);
        check("t1_latency", cyc, 32'd4);
        idle(3);
        check("t1_done_once", done_cnt - d0, 32'd1);
        check("t1_q_empty", expq.size(), 32'd0);

        push(38, 4);
        d0 = done_cnt;
        start_scan(38, 4);
        wait_done(20, 1'b0, cyc);
        idle(3);
        check("t2_done_once", done_cnt - d0, 32'd1);
        check("t2_q_empty", expq.size(), 32'd0);

        push(0, 40);
        d0 = done_cnt;
        start_scan(0, 40);
        wait_done(200, 1'b1, cyc);
        out_ready = 1'b1;
        idle(3);
        check("t3_done_once", done_cnt - d0, 32'd1);
        check("t3_q_empty", expq.size(), 32'd0);

        for (int k = 0; k < 3; k++) begin
            start_scan(bad_a[k], bad_n[k]);
            check("err_pulse", {29'd0, err, busy, out_valid}, 32'b100);
            @(posedge clk); #1;
            check("err_cleared", {30'd0, err, busy}, 32'd0);
        end

        push(10, 3);
        d0 = done_cnt;
        start_scan(10, 10);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (out_valid && out_addr == 6'd12) break;
        end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_state", {30'd0, out_valid, busy}, 32'd0);
        idle(4);
        check("abort_no_done", done_cnt - d0, 32'd0);
        check("abort_q_empty", expq.size(), 32'd0);

        push(20, 2);
        d0 = done_cnt;
        start_scan(20, 2);
        wait_done(20, 1'b0, cyc);
        idle(2);
        check("restart_done", done_cnt - d0, 32'd1);

`ifdef REG40_SCAN_FWD_EN
        expq.push_back({6'd7, 8'hAB});
`else
        expq.push_back({6'd7, 8'd107});
`endif
        start_scan(7, 1);
        wr_en = 1'b1; wr_addr = 6'd7; wr_data = 8'hAB;
        @(posedge clk);
        file[7] <= 8'hAB;
        #1;
        wr_en = 1'b0;
        wait_done(20, 1'b0, cyc);
        file[7] = 8'd107;
        idle(2);
        check("final_q_empty", expq.size(), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
